// File: rtl/axis_tx_arb.sv
// Packet-granular 2:1 round-robin arbiter feeding the MAC Tx user stream.
// Ownership is held for a whole packet; the output beat is fully registered.
module axis_tx_arb #(
  parameter int CNT_W = 32
) (
  input  logic             s_axis_aclk,
  input  logic             s_axis_aresetn,
  input  logic [63:0]      s0_axis_tdata,
  input  logic [7:0]       s0_axis_tkeep,
  input  logic             s0_axis_tvalid,
  input  logic             s0_axis_tlast,
  output logic             s0_axis_tready,
  input  logic [63:0]      s1_axis_tdata,
  input  logic [7:0]       s1_axis_tkeep,
  input  logic             s1_axis_tvalid,
  input  logic             s1_axis_tlast,
  output logic             s1_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [1:0]       grant
);

  // Handshake: a beat moves on a port only in a cycle where its tvalid and
  // tready are both 1; tvalid never waits on tready, and data is held stable
  // by the sender while tvalid=1 and tready=0.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_served_q;
  logic             sel_valid, sel_last, sel_ready, accept;
  logic [63:0]      sel_data;
  logic [7:0]       sel_keep;
  logic [63:0]      m_data_q;
  logic [7:0]       m_keep_q;
  logic             m_valid_q, m_last_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    if (grant_q[0]) begin
      sel_valid = s0_axis_tvalid;
      sel_last  = s0_axis_tlast;
      sel_data  = s0_axis_tdata;
      sel_keep  = s0_axis_tkeep;
    end else if (grant_q[1]) begin
      sel_valid = s1_axis_tvalid;
      sel_last  = s1_axis_tlast;
      sel_data  = s1_axis_tdata;
      sel_keep  = s1_axis_tkeep;
    end
  end

  assign accept = sel_valid & sel_ready;

  // FSM: state register
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // FSM: next state; on contention the port not served last wins
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid && (!s1_axis_tvalid || last_served_q)) begin
          state_d = BUSY;
          grant_d = 2'b01;
        end else if (s1_axis_tvalid) begin
          state_d = BUSY;
          grant_d = 2'b10;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    sel_ready      = (state_q == BUSY) && (!m_valid_q || m_axis_tready);
    s0_axis_tready = sel_ready & grant_q[0];
    s1_axis_tready = sel_ready & grant_q[1];
  end

  // Output register runs independently of the FSM so a final beat drains in IDLE.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= sel_data;
      m_keep_q  <= sel_keep;
      m_last_q  <= sel_last;
    end else if (m_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      last_served_q <= 1'b1;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
    end else if (accept && sel_last) begin
      last_served_q <= grant_q[1];
      if (grant_q[0]) cnt0_q <= cnt0_q + 1'b1;
      if (grant_q[1]) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign pkt_cnt0      = cnt0_q;
  assign pkt_cnt1      = cnt1_q;
  assign grant         = grant_q;

endmodule

// File: tb/tb_axis_tx_arb.sv
// Directed bench for axis_tx_arb: queue-fed requesters, output monitor and
// per-scenario tasks with hand-computed expectations.
module tb_axis_tx_arb;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [63:0]      s0_tdata, s1_tdata, m_tdata;
  logic [7:0]       s0_tkeep, s1_tkeep, m_tkeep;
  logic             s0_tvalid, s1_tvalid, m_tvalid;
  logic             s0_tlast, s1_tlast, m_tlast;
  logic             s0_tready, s1_tready, m_tready;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;
  logic [1:0]       grant;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_viol = 0;
  int rdy_viol = 0;

  logic [63:0] q0_d[$], q1_d[$];
  logic [7:0]  q0_k[$], q1_k[$];
  logic        q0_l[$], q1_l[$];
  logic [72:0] exp_q[$];
  logic [72:0] obs_q[$];
  int          obs_cyc[$];
  logic        hs0 = 1'b0, hs1 = 1'b0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_pat = 16'b1011_0010_0110_1101;
  int          bp_idx = 0;
  logic        prev_stall = 1'b0;
  logic [72:0] prev_beat = '0;

  axis_tx_arb #(.CNT_W(CNT_W)) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s0_axis_tdata  (s0_tdata),
    .s0_axis_tkeep  (s0_tkeep),
    .s0_axis_tvalid (s0_tvalid),
    .s0_axis_tlast  (s0_tlast),
    .s0_axis_tready (s0_tready),
    .s1_axis_tdata  (s1_tdata),
    .s1_axis_tkeep  (s1_tkeep),
    .s1_axis_tvalid (s1_tvalid),
    .s1_axis_tlast  (s1_tlast),
    .s1_axis_tready (s1_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tready  (m_tready),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1),
    .grant          (grant)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // requester and sink drivers: inputs change 1 time unit after the rising edge
  initial begin
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0;
    m_tready  = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (hs0 && q0_d.size() > 0) begin
        q0_d.delete(0); q0_k.delete(0); q0_l.delete(0);
      end
      if (hs1 && q1_d.size() > 0) begin
        q1_d.delete(0); q1_k.delete(0); q1_l.delete(0);
      end
      if (q0_d.size() > 0) begin
        s0_tvalid = 1'b1; s0_tdata = q0_d[0]; s0_tkeep = q0_k[0]; s0_tlast = q0_l[0];
      end else begin
        s0_tvalid = 1'b0;
      end
      if (q1_d.size() > 0) begin
        s1_tvalid = 1'b1; s1_tdata = q1_d[0]; s1_tkeep = q1_k[0]; s1_tlast = q1_l[0];
      end else begin
        s1_tvalid = 1'b0;
      end
      if (bp_en) begin
        m_tready = bp_pat[bp_idx % 16];
        bp_idx++;
      end else begin
        m_tready = 1'b1;
      end
    end
  end

  // output monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      hs0 = s0_tvalid & s0_tready;
      hs1 = s1_tvalid & s1_tready;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (m_tvalid !== 1'b1 || {m_tlast, m_tkeep, m_tdata} !== prev_beat))
          stall_viol++;
        if (m_tvalid && m_tready) begin
          obs_q.push_back({m_tlast, m_tkeep, m_tdata});
          obs_cyc.push_back(cyc);
        end
        if (m_tvalid && !m_tready && (s0_tready || s1_tready))
          rdy_viol++;
        prev_stall = m_tvalid & ~m_tready;
        prev_beat  = {m_tlast, m_tkeep, m_tdata};
      end
    end
  end

  task automatic push(input int p, input logic [63:0] d, input logic [7:0] k, input logic l);
    if (p == 0) begin
      q0_d.push_back(d); q0_k.push_back(k); q0_l.push_back(l);
    end else begin
      q1_d.push_back(d); q1_k.push_back(k); q1_l.push_back(l);
    end
    exp_q.push_back({l, k, d});
  endtask

  task automatic rst_assert();
    rst_n = 1'b0;
    q0_d.delete(); q0_k.delete(); q0_l.delete();
    q1_d.delete(); q1_k.delete(); q1_l.delete();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    hs0 = 1'b0; hs1 = 1'b0;
    bp_en = 1'b0; stall_viol = 0; rdy_viol = 0;
  endtask

  task automatic rst_release();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q0_d.size() == 0 && q1_d.size() == 0 && obs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_assert();
    @(negedge clk);
    checks++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== 74'd0) begin
      errors++;
      $display("FAIL reset_out: got v=%b l=%b k=%h d=%h, required all zero",
               m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    checks++;
    if ({s0_tready, s1_tready, grant} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready_grant: got rdy0=%b rdy1=%b grant=%b, required 0 0 00",
               s0_tready, s1_tready, grant);
    end
    checks++;
    if (pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
    end
    rst_release();
  endtask

  task automatic test_single();
    bit ok;
    bit seen;
    rst_assert();
    rst_release();
    push(0, 64'h1111_1111_1111_1111, 8'hFF, 1'b0);
    push(0, 64'h2222_2222_2222_2222, 8'hFF, 1'b0);
    push(0, 64'h3333_3333_3333_3333, 8'h0F, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s0_tvalid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || grant !== 2'b00 || s0_tready !== 1'b0) begin
      errors++;
      $display("FAIL single_arb_cycle: valid_seen=%b grant=%b rdy0=%b, required 1 00 0",
               seen, grant, s0_tready);
    end
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("FAIL single_grant: got %b, required 01", grant);
    end
    wait_drain(3, 50, ok);
    checks++;
    if (!ok || obs_q.size() != 3) begin
      errors++;
      $display("FAIL single_count: got %0d beats (drained=%b), required 3", obs_q.size(), ok);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL single_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[1] + 1) begin
        errors++;
        $display("FAIL single_throughput: cycles %0d %0d %0d, required consecutive",
                 obs_cyc[0], obs_cyc[1], obs_cyc[2]);
      end
    end
    checks++;
    if (pkt_cnt0 !== 4'd1 || pkt_cnt1 !== 4'd0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL single_cnt: got cnt0=%0d cnt1=%0d grant=%b, required 1 0 00",
               pkt_cnt0, pkt_cnt1, grant);
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic [72:0] e[$];
    rst_assert();
    for (int i = 0; i < 4; i++) begin
      q0_d.push_back({8'hA0, 56'(i)}); q0_k.push_back(8'hFF); q0_l.push_back(1'b1);
      q1_d.push_back({8'hB1, 56'(i)}); q1_k.push_back(8'hFF); q1_l.push_back(1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      e.push_back({1'b1, 8'hFF, 8'hA0, 56'(i)});
      e.push_back({1'b1, 8'hFF, 8'hB1, 56'(i)});
    end
    rst_release();
    wait_drain(8, 100, ok);
    checks++;
    if (!ok || obs_q.size() != 8) begin
      errors++;
      $display("FAIL contention_count: got %0d beats, required 8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_q[i] !== e[i]) begin
          errors++;
          $display("FAIL contention_order%0d: got %h, required %h", i, obs_q[i], e[i]);
        end
      end
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (obs_cyc[i+1] - obs_cyc[i] != 2) begin
          errors++;
          $display("FAIL contention_gap%0d: got %0d cycles, required 2", i,
                   obs_cyc[i+1] - obs_cyc[i]);
        end
      end
    end
    checks++;
    if (pkt_cnt0 !== 4'd4 || pkt_cnt1 !== 4'd4) begin
      errors++;
      $display("FAIL contention_cnt: got %0d/%0d, required 4/4", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    rst_assert();
    rst_release();
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++)
      push(1, {8'hB1, 48'h0, 8'(i * 7 + 3)}, (i == 9) ? 8'h03 : 8'hFF, i == 9);
    wait_drain(10, 300, ok);
    bp_en = 1'b0;
    checks++;
    if (!ok || obs_q.size() != 10) begin
      errors++;
      $display("FAIL bp_count: got %0d beats, required 10", obs_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable stalled cycles, required 0", stall_viol);
    end
    checks++;
    if (rdy_viol != 0) begin
      errors++;
      $display("FAIL bp_ready: got %0d ready-while-stalled cycles, required 0", rdy_viol);
    end
    checks++;
    if (pkt_cnt1 !== 4'd1 || pkt_cnt0 !== 4'd0) begin
      errors++;
      $display("FAIL bp_cnt: got %0d/%0d, required 0/1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_no_interleave();
    bit ok;
    int n, last_acc, first_s1, viol;
    logic [1:0] idle_grant;
    rst_assert();
    rst_release();
    for (int i = 0; i < 6; i++)
      push(0, {8'hA0, 48'h0, 8'(i)}, 8'hFF, i == 5);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s0_tvalid && s0_tready) break;
    end
    push(1, {8'hB1, 56'h10}, 8'hFF, 1'b0);
    push(1, {8'hB1, 56'h11}, 8'h01, 1'b1);
    n = 0; last_acc = -1; first_s1 = -1; viol = 0; idle_grant = 2'b11;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (s1_tready && last_acc < 0) viol++;
      if (last_acc >= 0 && n == last_acc + 1) idle_grant = grant;
      if (s0_tvalid && s0_tready && s0_tlast) last_acc = n;
      if (s1_tvalid && s1_tready) begin
        first_s1 = n;
        break;
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL noint_ready: s1 ready %0d times before s0 tlast, required 0", viol);
    end
    checks++;
    if (last_acc < 0 || first_s1 != last_acc + 2 || idle_grant !== 2'b00) begin
      errors++;
      $display("FAIL noint_bubble: s0 last at %0d, s1 first at %0d, gap grant=%b, required last+2 and 00",
               last_acc, first_s1, idle_grant);
    end
    wait_drain(8, 60, ok);
    checks++;
    if (!ok || obs_q.size() != 8 || obs_q != exp_q) begin
      errors++;
      $display("FAIL noint_order: got %0d beats, first=%h last=%h, required 8 beats s0x6 then s1x2",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 73'h0,
               (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 73'h0);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit hit;
    int k;
    rst_assert();
    rst_release();
    push(0, {8'hA0, 56'h99}, 8'hFF, 1'b1);
    wait_drain(1, 30, ok);
    for (int i = 0; i < 5; i++)
      push(0, {8'hA0, 48'h0, 8'(i)}, 8'hFF, i == 4);
    k = 0; hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s0_tvalid && s0_tready) begin
        if (k == 2) begin
          hit = 1'b1;
          break;
        end
        k++;
      end
    end
    #1;
    rst_assert();
    #1;
    checks++;
    if (!hit || m_tvalid !== 1'b0 || grant !== 2'b00 || m_tdata !== 64'h0) begin
      errors++;
      $display("FAIL midrst_async: beat3_seen=%b v=%b grant=%b d=%h, required 1 0 00 0",
               hit, m_tvalid, grant, m_tdata);
    end
    checks++;
    if (pkt_cnt0 !== 4'd0 || pkt_cnt1 !== 4'd0) begin
      errors++;
      $display("FAIL midrst_cnt: got %0d/%0d, required 0/0", pkt_cnt0, pkt_cnt1);
    end
    push(1, {8'hB1, 56'h1}, 8'hFF, 1'b1);
    push(0, {8'hA0, 56'h1}, 8'hFF, 1'b1);
    rst_release();
    wait_drain(2, 30, ok);
    checks++;
    if (!ok || obs_q.size() != 2 || obs_q[0][63:56] !== 8'hA0 || obs_q[1][63:56] !== 8'hB1) begin
      errors++;
      $display("FAIL midrst_prio: got %0d beats first=%h, required s0 (A0) first then s1 (B1)",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 73'h0);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    rst_assert();
    rst_release();
    for (int i = 0; i < 17; i++)
      push(1, {8'hB1, 56'(i)}, 8'hFF, 1'b1);
    wait_drain(17, 200, ok);
    checks++;
    if (!ok || pkt_cnt1 !== 4'd1 || pkt_cnt0 !== 4'd0) begin
      errors++;
      $display("FAIL wrap_cnt: got cnt1=%0d cnt0=%0d (drained=%b), required 1 0",
               pkt_cnt1, pkt_cnt0, ok);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_no_interleave();
    test_mid_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
